// File: rtl/opb_swreg_pkg.sv
// opb_swreg_pkg: register offsets, status bit indices and bus FSM states shared by the OPB software registers.
package opb_swreg_pkg;
  localparam logic [7:0] DATA_OFF    = 8'h00;
  localparam logic [7:0] STATUS_OFF  = 8'h04;
  localparam logic [7:0] CONTROL_OFF = 8'h08;
  localparam int ST_VALID    = 0;
  localparam int ST_OVERRUN  = 1;
  localparam int CTRL_FREEZE = 0;
  typedef enum logic {IDLE, ACK} bus_state_e;
endpackage

// File: rtl/opb_slave_decode.sv
// opb_slave_decode: OPB window decode, IDLE/ACK handshake FSM, registered read data and latched write fields.
module opb_slave_decode
  import opb_swreg_pkg::*;
#(
  parameter logic [31:0] BASE = 32'h01102200,
  parameter logic [31:0] HIGH = 32'h011022FF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [0:31] abus,
  input  logic [0:3]  be,
  input  logic [0:31] dbus,
  input  logic        rnw,
  input  logic        select,
  input  logic [31:0] rd_data,
  output logic        ack,
  output logic [0:31] sl_dbus,
  output logic [7:0]  cur_off,
  output logic [7:0]  off_q,
  output logic        rnw_q,
  output logic [0:3]  be_q,
  output logic [31:0] wdata_q
);
  bus_state_e state_q, state_d;
  logic        take;
  logic [0:31] dbus_q, dbus_d;
  logic [7:0]  off_d;
  logic        rnw_d;
  logic [0:3]  be_d;
  logic [31:0] wdata_d;
  always_comb begin
    cur_off = {abus[24:29], 2'b00};
    take    = state_q == IDLE && select && abus >= BASE && abus <= HIGH;
    state_d = take ? ACK : IDLE;
    dbus_d  = (take && rnw) ? rd_data : '0;
    off_d   = take ? cur_off : off_q;
    rnw_d   = take ? rnw : rnw_q;
    be_d    = take ? be : be_q;
    wdata_d = take ? dbus : wdata_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      dbus_q  <= '0;
      off_q   <= '0;
      rnw_q   <= 1'b0;
      be_q    <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      dbus_q  <= dbus_d;
      off_q   <= off_d;
      rnw_q   <= rnw_d;
      be_q    <= be_d;
      wdata_q <= wdata_d;
    end
  end
  assign ack     = state_q == ACK;
  assign sl_dbus = dbus_q;
endmodule

// File: rtl/opb_register_simulink2ppc_snap.sv
// opb_register_simulink2ppc_snap: captures a fabric word on user_valid and returns it over OPB with status/freeze control.
// Optional capture counter in STATUS[31:16] is built when SIMULINK2PPC_CAPCOUNT_EN is defined.
module opb_register_simulink2ppc_snap
  import opb_swreg_pkg::*;
#(
  parameter logic [31:0] C_BASEADDR   = 32'h01102200,
  parameter logic [31:0] C_HIGHADDR   = 32'h011022FF,
  parameter int          C_OPB_AWIDTH = 32,
  parameter int          C_OPB_DWIDTH = 32,
  parameter              C_FAMILY     = "virtex6"
) (
  input  logic                    OPB_Clk,
  input  logic                    OPB_Rst,
  input  logic [0:C_OPB_AWIDTH-1] OPB_ABus,
  input  logic [0:3]              OPB_BE,
  input  logic [0:C_OPB_DWIDTH-1] OPB_DBus,
  input  logic                    OPB_RNW,
  input  logic                    OPB_select,
  input  logic                    OPB_seqAddr,
  output logic [0:C_OPB_DWIDTH-1] Sl_DBus,
  output logic                    Sl_xferAck,
  output logic                    Sl_errAck,
  output logic                    Sl_retry,
  output logic                    Sl_toutSup,
  input  logic [31:0]             user_data_in,
  input  logic                    user_valid
);
  logic        ack, rnw_q;
  logic [7:0]  cur_off, off_q;
  logic [0:3]  be_q;
  logic [31:0] wdata_q, rd_data, status;
  logic [31:0] data_q, data_d;
  logic        valid_q, valid_d, overrun_q, overrun_d, freeze_q, freeze_d;
  logic        cap, wr_st, rd_clr, ovr_clr;
  logic [15:0] count;
  logic        unused_ok;
  opb_slave_decode #(.BASE(C_BASEADDR), .HIGH(C_HIGHADDR)) u_dec (
    .clk(OPB_Clk), .rst(OPB_Rst), .abus(OPB_ABus), .be(OPB_BE), .dbus(OPB_DBus),
    .rnw(OPB_RNW), .select(OPB_select), .rd_data(rd_data), .ack(ack), .sl_dbus(Sl_DBus),
    .cur_off(cur_off), .off_q(off_q), .rnw_q(rnw_q), .be_q(be_q), .wdata_q(wdata_q)
  );
  always_comb begin
    cap       = user_valid && !freeze_q;
    wr_st     = ack && !rnw_q && off_q == STATUS_OFF;
    rd_clr    = ack && rnw_q && off_q == DATA_OFF;
    ovr_clr   = wr_st && be_q[3] && wdata_q[ST_OVERRUN];
    data_d    = cap ? user_data_in : data_q;
    valid_d   = cap || (valid_q && !rd_clr);
    overrun_d = (cap && valid_q && !rd_clr) || (overrun_q && !ovr_clr);
    freeze_d  = (ack && !rnw_q && off_q == CONTROL_OFF && be_q[3]) ? wdata_q[CTRL_FREEZE] : freeze_q;
    status    = '0;
    status[ST_VALID]   = valid_q;
    status[ST_OVERRUN] = overrun_q;
    status[31:16]      = count;
    rd_data = cur_off == DATA_OFF    ? data_q :
              cur_off == STATUS_OFF  ? status :
              cur_off == CONTROL_OFF ? {31'h0, freeze_q} : '0;
  end
  always_ff @(posedge OPB_Clk) begin
    if (OPB_Rst) begin
      data_q    <= '0;
      valid_q   <= 1'b0;
      overrun_q <= 1'b0;
      freeze_q  <= 1'b0;
    end else begin
      data_q    <= data_d;
      valid_q   <= valid_d;
      overrun_q <= overrun_d;
      freeze_q  <= freeze_d;
    end
  end
`ifdef SIMULINK2PPC_CAPCOUNT_EN
  logic [15:0] count_q, count_d;
  always_comb count_d = (wr_st && be_q[0] && wdata_q[31]) ? '0 : cap ? count_q + 16'd1 : count_q;
  always_ff @(posedge OPB_Clk) begin
    if (OPB_Rst) count_q <= '0;
    else count_q <= count_d;
  end
  assign count = count_q;
`else
  assign count = '0;
`endif
  assign Sl_xferAck = ack;
  assign Sl_errAck  = 1'b0;
  assign Sl_retry   = 1'b0;
  assign Sl_toutSup = 1'b0;
  assign unused_ok  = &{1'b0, OPB_seqAddr, be_q, wdata_q, C_FAMILY};
endmodule

// File: tb/tb_opb_register_simulink2ppc_snap.sv
// tb_opb_register_simulink2ppc_snap: directed OPB transfers and captures with hand-computed expected values.
module tb_opb_register_simulink2ppc_snap;
  localparam logic [31:0] BASE = 32'h01102200;
  localparam logic [31:0] HIGH = 32'h011022FF;
`ifdef SIMULINK2PPC_CAPCOUNT_EN
  localparam logic [15:0] CMASK = 16'hFFFF;
`else
  localparam logic [15:0] CMASK = 16'h0000;
`endif
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [0:31] abus = '0, dbus = '0, sl_dbus;
  logic [0:3]  be = '0;
  logic        rnw = 1'b0, sel = 1'b0, seq = 1'b0;
  logic        ack, err, retry, tout;
  logic [31:0] udata = '0;
  logic        uvalid = 1'b0;
  logic [31:0] v;
  int asserts = 0, fails = 0;

  always #5 clk = ~clk;

  opb_register_simulink2ppc_snap dut (
    .OPB_Clk(clk), .OPB_Rst(rst), .OPB_ABus(abus), .OPB_BE(be), .OPB_DBus(dbus),
    .OPB_RNW(rnw), .OPB_select(sel), .OPB_seqAddr(seq), .Sl_DBus(sl_dbus),
    .Sl_xferAck(ack), .Sl_errAck(err), .Sl_retry(retry), .Sl_toutSup(tout),
    .user_data_in(udata), .user_valid(uvalid)
  );

  function automatic logic [31:0] st(input int c, input logic [1:0] f);
    return {c[15:0] & CMASK, 14'h0, f};
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    asserts++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic xfer(input logic [31:0] a, input logic r, input logic [31:0] w,
                      input logic ce, input logic [31:0] cd, output logic [31:0] rd);
    int n;
    n = 0;
    @(negedge clk);
    abus = a; rnw = r; dbus = w; be = 4'hF; sel = 1'b1;
    do begin
      @(negedge clk);
      n++;
    end while (!ack && n < 8);
    rd = sl_dbus;
    chk("ack_latency", n, 1);
    sel = 1'b0; rnw = 1'b0; dbus = '0; uvalid = ce; udata = cd;
    @(negedge clk);
    uvalid = 1'b0;
    chk("ack_single", {31'h0, ack}, 0);
    chk("dbus_idle", sl_dbus, 0);
  endtask

  task automatic rd_chk(input string tag, input logic [31:0] a, input logic [31:0] exp);
    logic [31:0] r;
    xfer(a, 1'b1, '0, 1'b0, '0, r);
    chk(tag, r, exp);
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] w);
    logic [31:0] r;
    xfer(a, 1'b0, w, 1'b0, '0, r);
  endtask

  task automatic capture(input logic [31:0] d);
    @(negedge clk);
    uvalid = 1'b1; udata = d;
    @(negedge clk);
    uvalid = 1'b0;
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk("reset_ack", {31'h0, ack}, 0);
    chk("reset_dbus", sl_dbus, 0);
    chk("tied_zero", {29'h0, err, retry, tout}, 0);
    rst = 1'b0;
    rd_chk("rst_data", BASE + 0, 32'h0);
    rd_chk("rst_status", BASE + 4, 32'h0);
    rd_chk("rst_control", BASE + 8, 32'h0);
    capture(32'hDEADBEEF);
    rd_chk("cap_status", BASE + 4, st(1, 2'b01));
    rd_chk("cap_data", BASE + 0, 32'hDEADBEEF);
    rd_chk("cap_status_clr", BASE + 4, st(1, 2'b00));
    capture(32'h1);
    capture(32'h2);
    rd_chk("ovr_status", BASE + 4, st(3, 2'b11));
    wr(BASE + 4, 32'h2);
    rd_chk("ovr_cleared", BASE + 4, st(3, 2'b01));
    rd_chk("ovr_data", BASE + 0, 32'h2);
    wr(BASE + 8, 32'h1);
    rd_chk("freeze_ctrl", BASE + 8, 32'h1);
    capture(32'h55);
    rd_chk("freeze_status", BASE + 4, st(3, 2'b00));
    rd_chk("freeze_data", BASE + 0, 32'h2);
    wr(BASE + 8, 32'h0);
    capture(32'h55);
    rd_chk("unfreeze_data", BASE + 0, 32'h55);
    capture(32'h66);
    xfer(BASE + 0, 1'b1, '0, 1'b1, 32'h77, v);
    chk("rdcap_old", v, 32'h66);
    rd_chk("rdcap_status", BASE + 4, st(6, 2'b01));
    rd_chk("rdcap_data", BASE + 0, 32'h77);
    capture(32'hA);
    xfer(BASE + 4, 1'b0, 32'h2, 1'b1, 32'hB, v);
    rd_chk("ovrclr_race", BASE + 4, st(8, 2'b11));
    rd_chk("other_off", BASE + 8'hFC, 32'h0);
    @(negedge clk);
    abus = HIGH + 4; rnw = 1'b1; be = 4'hF; sel = 1'b1;
    repeat (8) begin
      @(negedge clk);
      chk("oor_ack", {31'h0, ack}, 0);
      chk("oor_dbus", sl_dbus, 0);
    end
    abus = BASE - 4;
    repeat (2) begin
      @(negedge clk);
      chk("below_ack", {31'h0, ack}, 0);
    end
    sel = 1'b0;
    wr(BASE + 8, 32'h1);
    @(negedge clk);
    abus = BASE + 4; rnw = 1'b1; sel = 1'b1; rst = 1'b1;
    @(negedge clk);
    chk("rst_mid_ack", {31'h0, ack}, 0);
    sel = 1'b0; rst = 1'b0;
    @(negedge clk);
    chk("rst_mid_ack2", {31'h0, ack}, 0);
    rd_chk("post_rst_status", BASE + 4, 32'h0);
    rd_chk("post_rst_control", BASE + 8, 32'h0);
    rd_chk("post_rst_data", BASE + 0, 32'h0);
`ifdef SIMULINK2PPC_CAPCOUNT_EN
    @(negedge clk);
    uvalid = 1'b1; udata = 32'h1234;
    repeat (65537) @(negedge clk);
    uvalid = 1'b0;
    rd_chk("count_wrap", BASE + 4, 32'h00010003);
    wr(BASE + 4, 32'h80000000);
    rd_chk("count_clr", BASE + 4, 32'h00000003);
`else
    @(negedge clk);
    uvalid = 1'b1; udata = 32'h1234;
    repeat (3) @(negedge clk);
    uvalid = 1'b0;
    rd_chk("no_count", BASE + 4, 32'h00000003);
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", asserts, fails);
    $finish;
  end
endmodule
